// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   REG_W            : register-specifier width (5 for MIPS)
//   DEF_CNT_W        : default performance counter width
//   DEF_MEM_TIMEOUT  : default MEM_WAIT watchdog threshold (must be >= 1)
//   state_e          : controller FSM states
//   ctrl_t           : bundle of stage-register enables and flushes
package hazard_pkg;

  localparam int unsigned REG_W           = 5;
  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_MEM_TIMEOUT = 64;

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;

  // Output rows, in the order of the struct fields above.
  localparam ctrl_t CtrlPass   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CtrlFreeze = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CtrlReset  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  localparam ctrl_t CtrlBranch = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CtrlLoadUse = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CtrlJump   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  // Load in EX writes a register the ID instruction actually reads; $0 never hazards.
  function automatic logic load_use(input logic             ex_mem_read,
                                    input logic [REG_W-1:0] ex_rt,
                                    input logic [REG_W-1:0] id_rs,
                                    input logic [REG_W-1:0] id_rt,
                                    input logic             id_uses_rs,
                                    input logic             id_uses_rt);
    return ex_mem_read && (ex_rt != '0) &&
           ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : increment this cycle (ignored at all-ones)
//   clr_i      : synchronous clear, wins over inc_i
//   count_o    : current count
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall/flush controller for the 5-stage MIPS core.
// Mealy outputs from FSM state and current stage fields; zero-cycle latency.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   id_rs/id_rt, id_uses_rs/rt  : ID source registers and whether they are read
//   id_jump                     : ID instruction is a jump
//   ex_mem_read, ex_rt          : load in EX and its destination
//   ex_branch_taken             : BEQ in EX resolved taken
//   mem_req, mem_ready          : MEM-stage data memory handshake
//   cnt_clr                     : synchronous clear of counters and mem_timeout
//   pc_write..exmem_write       : stage register write-enables
//   ifid_flush, idex_flush      : load a nop into IF/ID, ID/EX
//   memwb_bubble                : load a nop into MEM/WB
//   mem_timeout                 : sticky watchdog flag
//   stall_cnt, flush_cnt        : saturating performance counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic             lu;
  logic             freeze;
  ctrl_t            ctrl;

  assign lu = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // In MEM_WAIT the outstanding access keeps the pipe frozen even if mem_req drops.
  assign freeze = (state_q == StMemWait) ? !mem_ready : (mem_req && !mem_ready);

  always_comb begin
    ctrl = CtrlPass;
    if (!rst_n) begin
      ctrl = CtrlReset;
    end else if (freeze) begin
      ctrl = CtrlFreeze;
    end else if (ex_branch_taken) begin
      // ID/IF hold wrong-path instructions, so lu and id_jump are moot.
      ctrl = CtrlBranch;
    end else if (lu) begin
      ctrl = CtrlLoadUse;
    end else if (id_jump) begin
      ctrl = CtrlJump;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StRun: begin
        wait_d = '0;
        if (mem_req && !mem_ready) begin
          state_d = StMemWait;
        end
      end
      StMemWait: begin
        if (mem_ready) begin
          state_d = StRun;
        end else if (wait_q != WaitMax) begin
          wait_d = wait_q + 1'b1;
          if (wait_q == WaitMax - 1'b1) begin
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = StRun;
    endcase
    if (cnt_clr) begin
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (!ctrl.pc_write),
    .clr_i  (cnt_clr),
    .count_o(stall_cnt)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (ctrl.ifid_flush),
    .clr_i  (cnt_clr),
    .count_o(flush_cnt)
  );

  assign pc_write     = ctrl.pc_write;
  assign ifid_write   = ctrl.ifid_write;
  assign idex_write   = ctrl.idex_write;
  assign exmem_write  = ctrl.exmem_write;
  assign ifid_flush   = ctrl.ifid_flush;
  assign idex_flush   = ctrl.idex_flush;
  assign memwb_bubble = ctrl.memwb_bubble;
  assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so saturation is reachable).
// Control outputs are packed as {pc,ifid,idex,exmem write, ifid,idex flush, memwb bubble}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_jump, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready, cnt_clr;
  logic       pc_write, ifid_write, idex_write, exmem_write;
  logic       ifid_flush, idex_flush, memwb_bubble, mem_timeout;
  logic [3:0] stall_cnt, flush_cnt;
  logic [6:0] ctl;

  int compared = 0;
  int mismatched = 0;

  localparam logic [6:0] PassV   = 7'b1111_000;
  localparam logic [6:0] FreezeV = 7'b0000_001;
  localparam logic [6:0] ResetV  = 7'b0000_111;
  localparam logic [6:0] BranchV = 7'b1111_110;
  localparam logic [6:0] LuV     = 7'b0011_010;
  localparam logic [6:0] JumpV   = 7'b1111_100;

  assign ctl = {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble};

  hazard_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .id_jump        (id_jump),
    .ex_mem_read    (ex_mem_read),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .cnt_clr        (cnt_clr),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .idex_write     (idex_write),
    .exmem_write    (exmem_write),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .memwb_bubble   (memwb_bubble),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    compared++; if (ctl !== ResetV) begin mismatched++; $display("FAIL rst_ctl: got %b want %b", ctl, ResetV); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL rst_stall: got %0d want 0", stall_cnt); end
    compared++; if (flush_cnt !== 4'd0) begin mismatched++; $display("FAIL rst_flush: got %0d want 0", flush_cnt); end
    compared++; if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL rst_timeout: got %b want 0", mem_timeout); end
    // Hazard inputs must not leak through while in reset.
    mem_req = 1'b1; ex_branch_taken = 1'b1; #1;
    compared++; if (ctl !== ResetV) begin mismatched++; $display("FAIL rst_ctl_inputs: got %b want %b", ctl, ResetV); end
    tick();
    clear_inputs();
    rst_n = 1'b1;
    #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL rst_release: got %b want %b", ctl, PassV); end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2; id_uses_rs = 1'b1; #1;
    compared++; if (ctl !== LuV) begin mismatched++; $display("FAIL lu_rs: got %b want %b", ctl, LuV); end
    tick();
    clear_inputs(); mem_req = 1'b1; mem_ready = 1'b1; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL lu_release: got %b want %b", ctl, PassV); end
    compared++; if (stall_cnt !== 4'd1) begin mismatched++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    clear_inputs(); ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; id_rs = 5'd7; #1;
    compared++; if (ctl !== LuV) begin mismatched++; $display("FAIL lu_rt: got %b want %b", ctl, LuV); end
    tick();
    id_uses_rt = 1'b0; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL lu_unused_field: got %b want %b", ctl, PassV); end
    tick();
    compared++; if (stall_cnt !== 4'd2) begin mismatched++; $display("FAIL lu_stall_cnt2: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b1; id_uses_rt = 1'b1; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL zero_reg: got %b want %b", ctl, PassV); end
    tick();
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL zero_reg_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; id_uses_rs = 1'b1;
    id_jump = 1'b1; ex_branch_taken = 1'b1; #1;
    compared++; if (ctl !== BranchV) begin mismatched++; $display("FAIL branch: got %b want %b", ctl, BranchV); end
    tick();
    clear_inputs(); #1;
    compared++; if (flush_cnt !== 4'd1) begin mismatched++; $display("FAIL branch_flush_cnt: got %0d want 1", flush_cnt); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL branch_stall_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_jump();
    do_reset();
    id_jump = 1'b1; #1;
    compared++; if (ctl !== JumpV) begin mismatched++; $display("FAIL jump: got %b want %b", ctl, JumpV); end
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_uses_rs = 1'b1; #1;
    compared++; if (ctl !== LuV) begin mismatched++; $display("FAIL jump_vs_lu: got %b want %b", ctl, LuV); end
    tick();
    clear_inputs(); #1;
    compared++; if (flush_cnt !== 4'd1) begin mismatched++; $display("FAIL jump_flush_cnt: got %0d want 1", flush_cnt); end
    compared++; if (stall_cnt !== 4'd1) begin mismatched++; $display("FAIL jump_stall_cnt: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) mem_req = 1'b0;  // still frozen: access is outstanding
      #1;
      compared++; if (ctl !== FreezeV) begin mismatched++; $display("FAIL mw_freeze%0d: got %b want %b", i, ctl, FreezeV); end
      tick();
    end
    mem_req = 1'b1; mem_ready = 1'b1; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL mw_ready: got %b want %b", ctl, PassV); end
    tick();
    clear_inputs(); #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL mw_run: got %b want %b", ctl, PassV); end
    compared++; if (stall_cnt !== 4'd3) begin mismatched++; $display("FAIL mw_stall_cnt: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1; #1;
    compared++; if (ctl !== LuV) begin mismatched++; $display("FAIL b2b_ready_lu: got %b want %b", ctl, LuV); end
    tick();
    clear_inputs(); mem_req = 1'b1; mem_ready = 1'b0; #1;
    compared++; if (ctl !== FreezeV) begin mismatched++; $display("FAIL b2b_reenter: got %b want %b", ctl, FreezeV); end
    for (int i = 0; i < 4; i++) tick();
    compared++; if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL b2b_wait_restart: got %b want 0", mem_timeout); end
    mem_ready = 1'b1; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL b2b_done: got %b want %b", ctl, PassV); end
    tick();
    compared++; if (stall_cnt !== 4'd9) begin mismatched++; $display("FAIL b2b_stall_cnt: got %0d want 9", stall_cnt); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      compared++;
      if (mem_timeout !== (i >= 4)) begin
        mismatched++; $display("FAIL to_flag%0d: got %b want %b", i, mem_timeout, (i >= 4));
      end
    end
    compared++; if (stall_cnt !== 4'd6) begin mismatched++; $display("FAIL to_stall_cnt: got %0d want 6", stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    compared++; if (mem_timeout !== 1'b0) begin mismatched++; $display("FAIL to_clr_flag: got %b want 0", mem_timeout); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL to_clr_cnt: got %0d want 0", stall_cnt); end
    cnt_clr = 1'b0; mem_ready = 1'b1; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL to_ready: got %b want %b", ctl, PassV); end
    tick();
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL to_post_cnt: got %0d want 0", stall_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    compared++; if (stall_cnt !== 4'hF) begin mismatched++; $display("FAIL sat_reach: got %0d want 15", stall_cnt); end
    tick(); tick();
    compared++; if (stall_cnt !== 4'hF) begin mismatched++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    compared++; if (stall_cnt !== 4'd3) begin mismatched++; $display("FAIL rw_pre_cnt: got %0d want 3", stall_cnt); end
    #2 rst_n = 1'b0; #1;
    compared++; if (ctl !== ResetV) begin mismatched++; $display("FAIL rw_rst_ctl: got %b want %b", ctl, ResetV); end
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL rw_rst_cnt: got %0d want 0", stall_cnt); end
    tick();
    rst_n = 1'b1; mem_req = 1'b0; mem_ready = 1'b0; #1;
    compared++; if (ctl !== PassV) begin mismatched++; $display("FAIL rw_run: got %b want %b", ctl, PassV); end
    tick();
    compared++; if (stall_cnt !== 4'd0) begin mismatched++; $display("FAIL rw_post_cnt: got %0d want 0", stall_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_jump();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_saturate();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
